// File: rtl/eth_pkg.sv
// Shared ARP/Ethernet constants and the resolver state encoding.
package eth_pkg;

    localparam logic [1:0]  ARP_OP_REQ = 2'd1;
    localparam logic [1:0]  ARP_OP_REP = 2'd2;
    localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_REQ  = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_SEND_RESP = 2'd3
    } arp_state_e;

endpackage

// File: rtl/arp_cache.sv
// Target MAC table: reply capture, retry/fail bookkeeping, periodic staleness
// marking and the combinational lookup port.
module arp_cache
    import eth_pkg::*;
#(
    parameter int                 N_TGT     = 4,
    parameter logic [47:0]        SELF_MAC  = 48'h0023543C471B,
    parameter logic [31:0]        SELF_IP   = 32'h0A000021,
    parameter logic [N_TGT*32-1:0] TGT_IPS  = {4{32'h0A000002}},
    parameter logic [31:0]        REFRESH   = 32'h1FFFFFFF,
    parameter int                 MAX_RETRY = 3,
    localparam int                IW        = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_arp_vld_i,
    input  logic [1:0]        rx_oper_i,
    input  logic [47:0]       rx_sha_i,
    input  logic [31:0]       rx_spa_i,
    input  logic [47:0]       rx_tha_i,
    input  logic [31:0]       rx_tpa_i,
    input  logic              retry_inc_i,
    input  logic              retry_clr_i,
    input  logic [IW-1:0]     cur_i,
    input  logic [IW-1:0]     tgt_sel_i,
    output logic [N_TGT-1:0]  need_o,
    output logic [N_TGT-1:0]  hit_o,
    output logic [N_TGT-1:0]  fail_o,
    output logic              retry_last_o,
    output logic [47:0]       tgt_mac_o,
    output logic              tgt_valid_o
);

    localparam int             RW        = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

    logic [31:0]         ref_cnt_q;
    logic                ref_wrap;
    logic                rep_ok;
    logic [N_TGT*48-1:0] mac_flat;
    logic [N_TGT-1:0]    valid_vec;
    logic [N_TGT-1:0]    last_vec;

    assign ref_wrap = (ref_cnt_q == REFRESH);
    assign rep_ok   = rx_arp_vld_i && (rx_oper_i == ARP_OP_REP) &&
                      (rx_tha_i == SELF_MAC) && (rx_tpa_i == SELF_IP);

    // Free-running refresh period counter, wraps after reaching REFRESH.
    always_ff @(posedge clk) begin
        if (!rst_n)        ref_cnt_q <= '0;
        else if (ref_wrap) ref_cnt_q <= '0;
        else               ref_cnt_q <= ref_cnt_q + 32'd1;
    end

    for (genvar gi = 0; gi < N_TGT; gi++) begin : g_entry
        localparam logic [IW-1:0] IDX = IW'(gi);

        logic [47:0]   mac_q;
        logic          valid_q;
        logic          stale_q;
        logic          fail_q;
        logic [RW-1:0] retry_q;
        logic [RW-1:0] retry_nxt;
        logic          sel;

        assign sel         = (cur_i == IDX);
        assign retry_nxt   = retry_q + 1'b1;
        assign hit_o[gi]   = rep_ok && (rx_spa_i == TGT_IPS[32*gi +: 32]);
        assign need_o[gi]  = (!valid_q || stale_q) && !fail_q;
        assign fail_o[gi]  = fail_q;
        assign last_vec[gi] = (retry_nxt == RETRY_MAX);
        assign valid_vec[gi] = valid_q;
        assign mac_flat[48*gi +: 48] = mac_q;

        // Entry update; later statements take priority, so a reply beats
        // both a same-cycle refresh wrap and a same-cycle timeout.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mac_q   <= '0;
                valid_q <= 1'b0;
                stale_q <= 1'b0;
                fail_q  <= 1'b0;
                retry_q <= '0;
            end else begin
                if (ref_wrap) begin
                    if (valid_q) stale_q <= 1'b1;
                    fail_q <= 1'b0;
                end
                if (sel && retry_inc_i) begin
                    if (retry_nxt == RETRY_MAX) begin
                        fail_q  <= 1'b1;
                        retry_q <= '0;
                    end else begin
                        retry_q <= retry_nxt;
                    end
                end
                if (sel && retry_clr_i) retry_q <= '0;
                if (hit_o[gi]) begin
                    mac_q   <= rx_sha_i;
                    valid_q <= 1'b1;
                    stale_q <= 1'b0;
                    fail_q  <= 1'b0;
                end
            end
        end
    end

    // Lookup and "this timeout exhausts the attempts" flag for the current entry;
    // an index with no entry behind it returns zeros.
    always_comb begin
        tgt_mac_o    = '0;
        tgt_valid_o  = 1'b0;
        retry_last_o = 1'b0;
        for (int i = 0; i < N_TGT; i++) begin
            if (tgt_sel_i == IW'(i)) begin
                tgt_mac_o   = mac_flat[48*i +: 48];
                tgt_valid_o = valid_vec[i];
            end
            if (cur_i == IW'(i)) retry_last_o = last_vec[i];
        end
    end

endmodule

// File: rtl/arp_resolver.sv
// ARP resolver: sequences requests for unresolved/stale targets, answers
// requests addressed to us, and drives the ARP sender command interface.
module arp_resolver
    import eth_pkg::*;
#(
    parameter int                  N_TGT     = 4,
    parameter logic [47:0]         SELF_MAC  = 48'h0023543C471B,
    parameter logic [31:0]         SELF_IP   = 32'h0A000021,
    parameter logic [N_TGT*32-1:0] TGT_IPS   = {4{32'h0A000002}},
    parameter logic [31:0]         TIMEOUT   = 32'h08FFFFFF,
    parameter logic [31:0]         REFRESH   = 32'h1FFFFFFF,
    parameter int                  MAX_RETRY = 3,
    localparam int                 IW        = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_arp_vld,
    input  logic [1:0]        rx_oper,
    input  logic [47:0]       rx_sha,
    input  logic [31:0]       rx_spa,
    input  logic [47:0]       rx_tha,
    input  logic [31:0]       rx_tpa,
    output logic              tx_en,
    output logic [1:0]        tx_oper,
    output logic [47:0]       tx_dst_mac,
    output logic [47:0]       tx_tha,
    output logic [31:0]       tx_tpa,
    input  logic              tx_ready,
    input  logic [IW-1:0]     tgt_sel,
    output logic [47:0]       tgt_mac,
    output logic              tgt_valid,
    output logic [N_TGT-1:0]  fail,
    output logic              busy
);

    arp_state_e       state_q, state_d;
    logic [IW-1:0]    cur_q, cur_d;
    logic [IW-1:0]    last_q, last_d;
    logic [31:0]      wait_q, wait_d;
    logic [IW-1:0]    pick;
    logic             pick_vld;
    logic [N_TGT-1:0] need, hit;
    logic             retry_last, retry_inc, retry_clr;
    logic             req_acc;
    logic             pend_q, newreq_q;
    logic [47:0]      sha_q, rsp_sha_q;
    logic [31:0]      spa_q, rsp_spa_q;

    assign req_acc = rx_arp_vld && (rx_oper == ARP_OP_REQ) && (rx_tpa == SELF_IP);
    assign busy    = (state_q != ST_IDLE);

    arp_cache #(
        .N_TGT     (N_TGT),
        .SELF_MAC  (SELF_MAC),
        .SELF_IP   (SELF_IP),
        .TGT_IPS   (TGT_IPS),
        .REFRESH   (REFRESH),
        .MAX_RETRY (MAX_RETRY)
    ) u_cache (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_arp_vld_i (rx_arp_vld),
        .rx_oper_i    (rx_oper),
        .rx_sha_i     (rx_sha),
        .rx_spa_i     (rx_spa),
        .rx_tha_i     (rx_tha),
        .rx_tpa_i     (rx_tpa),
        .retry_inc_i  (retry_inc),
        .retry_clr_i  (retry_clr),
        .cur_i        (cur_q),
        .tgt_sel_i    (tgt_sel),
        .need_o       (need),
        .hit_o        (hit),
        .fail_o       (fail),
        .retry_last_o (retry_last),
        .tgt_mac_o    (tgt_mac),
        .tgt_valid_o  (tgt_valid)
    );

    // Round-robin pick: first entry needing resolution after the last one finished.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N_TGT; k++) begin
            idx = (int'(last_q) + k) % N_TGT;
            if (!pick_vld && need[idx]) begin
                pick_vld = 1'b1;
                pick     = IW'(idx);
            end
        end
    end

    // FSM state, current entry, round-robin pointer and response-wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= IW'(N_TGT - 1);
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    // Next state; the pointer only advances once an entry is resolved or given
    // up on, so retries of one target happen back to back.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        wait_d    = wait_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_SEND_RESP;
                end else if (pick_vld) begin
                    state_d = ST_SEND_REQ;
                    cur_d   = pick;
                end
            end
            ST_SEND_REQ: begin
                if (tx_ready) begin
                    state_d = ST_WAIT_RESP;
                    wait_d  = '0;
                end
            end
            ST_WAIT_RESP: begin
                if (hit[cur_q]) begin
                    state_d   = ST_IDLE;
                    retry_clr = 1'b1;
                    last_d    = cur_q;
                end else if (wait_q == TIMEOUT) begin
                    state_d   = ST_IDLE;
                    retry_inc = 1'b1;
                    if (retry_last) last_d = cur_q;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_SEND_RESP: begin
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending reply: fields are snapshotted when the response starts so they stay
    // stable; a request arriving after the snapshot keeps pending set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            newreq_q  <= 1'b0;
            sha_q     <= '0;
            spa_q     <= '0;
            rsp_sha_q <= '0;
            rsp_spa_q <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_SEND_RESP) begin
                rsp_sha_q <= sha_q;
                rsp_spa_q <= spa_q;
                newreq_q  <= 1'b0;
            end
            if (state_q == ST_SEND_RESP && tx_ready && !newreq_q) pend_q <= 1'b0;
            if (req_acc) begin
                sha_q    <= rx_sha;
                spa_q    <= rx_spa;
                pend_q   <= 1'b1;
                newreq_q <= 1'b1;
            end
        end
    end

    // Sender command mux, decoded from the registered state.
    always_comb begin
        tx_en      = 1'b0;
        tx_oper    = 2'd0;
        tx_dst_mac = '0;
        tx_tha     = '0;
        tx_tpa     = '0;
        case (state_q)
            ST_SEND_REQ: begin
                tx_en      = 1'b1;
                tx_oper    = ARP_OP_REQ;
                tx_dst_mac = BCAST_MAC;
                for (int i = 0; i < N_TGT; i++) begin
                    if (cur_q == IW'(i)) tx_tpa = TGT_IPS[32*i +: 32];
                end
            end
            ST_SEND_RESP: begin
                tx_en      = 1'b1;
                tx_oper    = ARP_OP_REP;
                tx_dst_mac = rsp_sha_q;
                tx_tha     = rsp_sha_q;
                tx_tpa     = rsp_spa_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: 3 targets, short timeout and refresh period.
module tb_arp_resolver;

    localparam int          N_TGT    = 3;
    localparam logic [47:0] SELF_MAC = 48'h0023543C471B;
    localparam logic [31:0] SELF_IP  = 32'h0A000021;
    localparam logic [31:0] IP0      = 32'h0A000002;
    localparam logic [31:0] IP1      = 32'h0A000003;
    localparam logic [31:0] IP2      = 32'h0A000004;
    localparam int          TMO      = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_arp_vld;
    logic [1:0]  rx_oper;
    logic [47:0] rx_sha, rx_tha;
    logic [31:0] rx_spa, rx_tpa;
    logic        tx_en;
    logic [1:0]  tx_oper;
    logic [47:0] tx_dst_mac, tx_tha;
    logic [31:0] tx_tpa;
    logic        tx_ready;
    logic [1:0]  tgt_sel;
    logic [47:0] tgt_mac;
    logic        tgt_valid;
    logic [2:0]  fail;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    arp_resolver #(
        .N_TGT     (N_TGT),
        .SELF_MAC  (SELF_MAC),
        .SELF_IP   (SELF_IP),
        .TGT_IPS   ({IP2, IP1, IP0}),
        .TIMEOUT   (32'(TMO)),
        .REFRESH   (32'd1000),
        .MAX_RETRY (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_arp_vld (rx_arp_vld),
        .rx_oper    (rx_oper),
        .rx_sha     (rx_sha),
        .rx_spa     (rx_spa),
        .rx_tha     (rx_tha),
        .rx_tpa     (rx_tpa),
        .tx_en      (tx_en),
        .tx_oper    (tx_oper),
        .tx_dst_mac (tx_dst_mac),
        .tx_tha     (tx_tha),
        .tx_tpa     (tx_tpa),
        .tx_ready   (tx_ready),
        .tgt_sel    (tgt_sel),
        .tgt_mac    (tgt_mac),
        .tgt_valid  (tgt_valid),
        .fail       (fail),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_tx(input int maxc, output int cyc);
        cyc = 0;
        while (tx_en !== 1'b1 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        if (tx_en !== 1'b1) cyc = -1;
    endtask

    task automatic send_ready();
        $display("tx done: oper=%0d dst=%h tha=%h tpa=%h", tx_oper, tx_dst_mac, tx_tha, tx_tpa);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic send_reply(input logic [31:0] spa, input logic [47:0] sha);
        $display("rx reply: spa=%h sha=%h", spa, sha);
        rx_oper = 2'd2; rx_spa = spa; rx_sha = sha; rx_tha = SELF_MAC; rx_tpa = SELF_IP;
        rx_arp_vld = 1'b1;
        @(negedge clk);
        rx_arp_vld = 1'b0;
    endtask

    task automatic send_request(input logic [31:0] spa, input logic [47:0] sha);
        $display("rx request: spa=%h sha=%h", spa, sha);
        rx_oper = 2'd1; rx_spa = spa; rx_sha = sha; rx_tha = 48'h0; rx_tpa = SELF_IP;
        rx_arp_vld = 1'b1;
        @(negedge clk);
        rx_arp_vld = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_en !== 1'b0 || busy !== 1'b0 || tx_oper !== 2'd0 || tx_tpa !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: tx_en=%b busy=%b oper=%0d tpa=%h, required 0 0 0 0", tx_en, busy, tx_oper, tx_tpa);
        end
        tgt_sel = 2'd0; #1;
        n_checks++;
        if (tgt_valid !== 1'b0 || tgt_mac !== 48'h0 || fail !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_cache: valid=%b mac=%h fail=%b, required 0 0 000", tgt_valid, tgt_mac, fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_en !== 1'b1 || tx_oper !== 2'd1 || tx_tpa !== IP0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_req: tx_en=%b oper=%0d tpa=%h busy=%b, required 1 1 %h 1", tx_en, tx_oper, tx_tpa, busy, IP0);
        end
        n_checks++;
        if (tx_dst_mac !== 48'hFFFFFFFFFFFF || tx_tha !== 48'h0) begin
            n_fail++;
            $display("FAIL first_req_hdr: dst=%h tha=%h, required ffffffffffff 0", tx_dst_mac, tx_tha);
        end
    endtask

    task automatic test_resolve();
        int c;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_en !== 1'b1 || tx_tpa !== IP0) begin
            n_fail++;
            $display("FAIL req_hold: tx_en=%b tpa=%h, required 1 %h", tx_en, tx_tpa, IP0);
        end
        send_ready();
        n_checks++;
        if (tx_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_state: tx_en=%b busy=%b, required 0 1", tx_en, busy);
        end
        send_reply(IP0, 48'h001122334455);
        tgt_sel = 2'd0; #1;
        n_checks++;
        if (tgt_valid !== 1'b1 || tgt_mac !== 48'h001122334455) begin
            n_fail++;
            $display("FAIL lookup0: valid=%b mac=%h, required 1 001122334455", tgt_valid, tgt_mac);
        end
        tgt_sel = 2'd1; #1;
        n_checks++;
        if (tgt_valid !== 1'b0 || tgt_mac !== 48'h0) begin
            n_fail++;
            $display("FAIL lookup1_empty: valid=%b mac=%h, required 0 0", tgt_valid, tgt_mac);
        end
        wait_tx(20, c);
        n_checks++;
        if (c < 0 || tx_oper !== 2'd1 || tx_tpa !== IP1) begin
            n_fail++;
            $display("FAIL next_entry: cycles=%0d oper=%0d tpa=%h, required request to %h", c, tx_oper, tx_tpa, IP1);
        end
    endtask

    task automatic test_req_during_wait();
        int c;
        do_reset();
        wait_tx(5, c);
        send_ready();
        send_request(32'h0A000007, 48'hAABBCCDDEEFF);
        repeat (2) @(negedge clk);
        send_reply(IP0, 48'h0000000000A0);
        wait_tx(10, c);
        n_checks++;
        if (c < 0 || tx_oper !== 2'd2 || tx_tpa !== 32'h0A000007) begin
            n_fail++;
            $display("FAIL resp_cmd: cycles=%0d oper=%0d tpa=%h, required reply tpa 0a000007", c, tx_oper, tx_tpa);
        end
        n_checks++;
        if (tx_dst_mac !== 48'hAABBCCDDEEFF || tx_tha !== 48'hAABBCCDDEEFF) begin
            n_fail++;
            $display("FAIL resp_addr: dst=%h tha=%h, required aabbccddeeff both", tx_dst_mac, tx_tha);
        end
        send_ready();
        wait_tx(10, c);
        n_checks++;
        if (c < 0 || tx_oper !== 2'd1 || tx_tpa !== IP1) begin
            n_fail++;
            $display("FAIL after_resp: cycles=%0d oper=%0d tpa=%h, required request to %h", c, tx_oper, tx_tpa, IP1);
        end
    endtask

    task automatic test_retry();
        int c;
        do_reset();
        wait_tx(5, c);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (c < 0 || tx_oper !== 2'd1 || tx_tpa !== IP0 || fail !== 3'b000) begin
                n_fail++;
                $display("FAIL retry_req%0d: cycles=%0d oper=%0d tpa=%h fail=%b, required request to %h fail 000", k, c, tx_oper, tx_tpa, fail, IP0);
            end
            send_ready();
            wait_tx(300, c);
            n_checks++;
            if (c != TMO + 2) begin
                n_fail++;
                $display("FAIL retry_gap%0d: %0d cycles, required %0d", k, c, TMO + 2);
            end
        end
        n_checks++;
        if (tx_tpa !== IP1 || fail !== 3'b001) begin
            n_fail++;
            $display("FAIL give_up: tpa=%h fail=%b, required %h 001", tx_tpa, fail, IP1);
        end
        send_ready();
        send_reply(IP1, 48'h0000000000B1);
        wait_tx(10, c);
        n_checks++;
        if (c < 0 || tx_tpa !== IP2) begin
            n_fail++;
            $display("FAIL entry2_req: cycles=%0d tpa=%h, required %h", c, tx_tpa, IP2);
        end
    endtask

    task automatic test_reset_mid_tx();
        tgt_sel = 2'd1; #1;
        n_checks++;
        if (tx_en !== 1'b1 || tgt_valid !== 1'b1 || fail !== 3'b001) begin
            n_fail++;
            $display("FAIL pre_reset: tx_en=%b valid1=%b fail=%b, required 1 1 001", tx_en, tgt_valid, fail);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_en !== 1'b0 || tx_tpa !== 32'h0 || busy !== 1'b0 || fail !== 3'b000 || tgt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_tx_reset: tx_en=%b tpa=%h busy=%b fail=%b valid1=%b, required 0 0 0 000 0", tx_en, tx_tpa, busy, fail, tgt_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_refresh();
        int c;
        int bad;
        logic [31:0] ips [3];
        ips[0] = IP0; ips[1] = IP1; ips[2] = IP2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wait_tx(10, c);
            send_ready();
            send_reply(ips[k], 48'h0000000000C0 + 48'(k));
        end
        n_checks++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL all_resolved_idle: busy=%b tx_en=%b, required 0 0", busy, tx_en);
        end
        bad = 0;
        c = 0;
        while (tx_en !== 1'b1 && c < 1500) begin
            tgt_sel = 2'(c % 3); #1;
            if (tgt_valid !== 1'b1) bad++;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (tx_en !== 1'b1 || bad != 0) begin
            n_fail++;
            $display("FAIL refresh_wait: tx_en=%b invalid_samples=%0d, required 1 0", tx_en, bad);
        end
        for (int k = 0; k < 3; k++) begin
            wait_tx(10, c);
            tgt_sel = 2'(k); #1;
            n_checks++;
            if (c < 0 || tx_tpa !== ips[k] || tgt_valid !== 1'b1 || tgt_mac !== 48'h0000000000C0 + 48'(k)) begin
                n_fail++;
                $display("FAIL rerequest%0d: cycles=%0d tpa=%h valid=%b mac=%h, required %h 1 %h", k, c, tx_tpa, tgt_valid, tgt_mac, ips[k], 48'h0000000000C0 + 48'(k));
            end
            send_ready();
            send_reply(ips[k], 48'h0000000000D0 + 48'(k));
        end
        tgt_sel = 2'd3; #1;
        n_checks++;
        if (tgt_valid !== 1'b0 || tgt_mac !== 48'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL out_of_range: valid=%b mac=%h busy=%b, required 0 0 0", tgt_valid, tgt_mac, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_arp_vld = 1'b0; rx_oper = 2'd0;
        rx_sha = '0; rx_spa = '0; rx_tha = '0; rx_tpa = '0;
        tx_ready = 1'b0; tgt_sel = 2'd0;
        test_reset();
        test_resolve();
        test_req_during_wait();
        test_retry();
        test_reset_mid_tx();
        test_refresh();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
